// File: rtl/ec_pkg.sv
// ec_pkg: shared constants and helpers for the encoder output packer.
//
// Holds the default configuration of the packer, the quantities derived from
// it, and the layout of one assembled-pixel FIFO entry. Modules that are
// re-parameterised compute their own derived values with the same helpers.
//
// FIFO entry layout, MSB to LSB: {last, fmap[D_OUT-1:0], pindex[D_OUT*PINDEX_WIDTH-1:0]}
package ec_pkg;

  localparam int EC_N_PE         = 16;
  localparam int EC_D_OUT        = 64;
  localparam int EC_PINDEX_WIDTH = 2;
  localparam int EC_FIFO_DEPTH   = 4;
  localparam int EC_N_PIXELS     = 1024;

  // $clog2 that never returns 0, so counters always have at least one bit
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  // Entry width for the {last, fmap, pindex} packing order
  function automatic int entry_width(input int d_out, input int pindex_width);
    return 1 + d_out + d_out * pindex_width;
  endfunction

  localparam int G       = EC_D_OUT / EC_N_PE;
  localparam int GRP_W   = clog2_min1(G);
  localparam int PIX_W   = clog2_min1(EC_N_PIXELS);
  localparam int ENTRY_W = entry_width(EC_D_OUT, EC_PINDEX_WIDTH);

endpackage

// File: rtl/ec_word_fifo.sv
// ec_word_fifo: small synchronous FIFO for assembled pixel words.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset (empties the FIFO)
//   push         write push_data at the tail (ignored when full)
//   push_data    WIDTH-bit entry to store
//   pop          drop the head entry (ignored when empty)
//   full, empty  occupancy flags, from registered state only
//   head_data    current head entry; zero while empty
//
// Read/write pointers plus an occupancy count. DEPTH must be a power of two
// so the pointers wrap naturally.
module ec_word_fifo
  import ec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  // Gating the head keeps the outputs at zero out of reset and when drained
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage is not reset: an entry is only observed after it has been written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ec_out_packer.sv
// ec_out_packer: gathers PE-bank result beats into full output pixels.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_ready        beat handshake from the PE bank
//   in_bits[N_PE]            binarized channels, MSB = lowest channel of beat
//   in_pindex                per-channel pool indices, MSB field pairs with in_bits MSB
//   out_valid/out_ready      pixel handshake to fmap writer / unpool store
//   out_fmap[D_OUT]          channel c at bit D_OUT-1-c
//   out_pindex               channel c field counted from the MSB end
//   out_last                 marks pixel N_PIXELS-1 of a frame
//
// D_OUT/N_PE consecutive beats form one pixel; the last beat of a pixel is
// pushed together with the previously assembled beats into a small FIFO.
module ec_out_packer
  import ec_pkg::*;
#(
  parameter int N_PE         = EC_N_PE,
  parameter int D_OUT        = EC_D_OUT,
  parameter int PINDEX_WIDTH = EC_PINDEX_WIDTH,
  parameter int FIFO_DEPTH   = EC_FIFO_DEPTH,
  parameter int N_PIXELS     = EC_N_PIXELS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_PE-1:0]               in_bits,
  input  logic [N_PE*PINDEX_WIDTH-1:0]  in_pindex,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [D_OUT-1:0]              out_fmap,
  output logic [D_OUT*PINDEX_WIDTH-1:0] out_pindex,
  output logic                          out_last
);

  localparam int N_GRP  = D_OUT / N_PE;
  localparam int CNT_W  = clog2_min1(N_GRP);
  localparam int PCNT_W = clog2_min1(N_PIXELS);
  localparam int PIDX_W = D_OUT * PINDEX_WIDTH;
  localparam int BEAT_PW = N_PE * PINDEX_WIDTH;
  localparam int E_W    = entry_width(D_OUT, PINDEX_WIDTH);

  logic [CNT_W-1:0]  grp_cnt_q, grp_cnt_d;
  logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [D_OUT-1:0]  asm_fmap_q, asm_fmap_d;
  logic [PIDX_W-1:0] asm_pidx_q, asm_pidx_d;
  logic [E_W-1:0]    push_entry, head_entry;
  logic              last_beat, accept, push, pop;
  logic              fifo_full, fifo_empty;
  int                fmap_base, pidx_base;

  // in_ready depends on registered state only: a full FIFO blocks only the
  // pixel-completing beat, and a pop frees space for the following cycle
  always_comb begin
    last_beat = (grp_cnt_q == CNT_W'(N_GRP - 1));
    in_ready  = !(last_beat && fifo_full);
    accept    = in_valid && in_ready;
    push      = accept && last_beat;
    pop       = out_ready && !fifo_empty;
  end

  // Drop the accepted beat into its channel slice, MSB-first, and advance the
  // group / pixel counters; the pushed word includes this cycle's beat
  always_comb begin
    asm_fmap_d = asm_fmap_q;
    asm_pidx_d = asm_pidx_q;
    grp_cnt_d  = grp_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    fmap_base  = D_OUT - 1 - int'(grp_cnt_q) * N_PE;
    pidx_base  = PIDX_W - 1 - int'(grp_cnt_q) * BEAT_PW;
    if (accept) begin
      asm_fmap_d[fmap_base -: N_PE]    = in_bits;
      asm_pidx_d[pidx_base -: BEAT_PW] = in_pindex;
      grp_cnt_d = last_beat ? '0 : grp_cnt_q + CNT_W'(1);
    end
    if (push) begin
      pix_cnt_d = (pix_cnt_q == PCNT_W'(N_PIXELS - 1)) ? '0 : pix_cnt_q + PCNT_W'(1);
    end
    push_entry = {(pix_cnt_q == PCNT_W'(N_PIXELS - 1)), asm_fmap_d, asm_pidx_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grp_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      asm_fmap_q <= '0;
      asm_pidx_q <= '0;
    end else begin
      grp_cnt_q  <= grp_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      asm_fmap_q <= asm_fmap_d;
      asm_pidx_q <= asm_pidx_d;
    end
  end

  ec_word_fifo #(
    .WIDTH (E_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (head_entry)
  );

  assign out_valid = !fifo_empty;
  assign {out_last, out_fmap, out_pindex} = head_entry;

endmodule

// File: tb/tb_ec_out_packer.sv
// tb_ec_out_packer: self-checking bench for ec_out_packer in a small
// configuration (4 PEs, 8 channels, 2-entry FIFO, 3-pixel frames).
// A behavioural model keeps expected pixels in a queue, built by shifting
// each beat into a word, and predicts in_ready/out_valid and the head pixel.
module tb_ec_out_packer;

  localparam int N_PE         = 4;
  localparam int D_OUT        = 8;
  localparam int PINDEX_WIDTH = 2;
  localparam int FIFO_DEPTH   = 2;
  localparam int N_PIXELS     = 3;
  localparam int G            = D_OUT / N_PE;
  localparam int BPW          = N_PE * PINDEX_WIDTH;
  localparam int PW           = D_OUT * PINDEX_WIDTH;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_PE-1:0]      in_bits;
  logic [BPW-1:0]       in_pindex;
  logic                 out_valid;
  logic                 out_ready;
  logic [D_OUT-1:0]     out_fmap;
  logic [PW-1:0]        out_pindex;
  logic                 out_last;

  typedef struct {
    logic [D_OUT-1:0] fmap;
    logic [PW-1:0]    pidx;
    logic             last;
  } pixel_t;

  pixel_t           expQ[$];
  int               beatCount;
  int               pixelIndex;
  logic [D_OUT-1:0] accFmap;
  logic [PW-1:0]    accPidx;
  int               compared;
  int               mismatched;

  ec_out_packer #(
    .N_PE         (N_PE),
    .D_OUT        (D_OUT),
    .PINDEX_WIDTH (PINDEX_WIDTH),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .N_PIXELS     (N_PIXELS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bits    (in_bits),
    .in_pindex  (in_pindex),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_fmap   (out_fmap),
    .out_pindex (out_pindex),
    .out_last   (out_last)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it and report a mismatch
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // A beat is refused only when it would complete a pixel into a full buffer
  function automatic bit modelReady();
    return !(beatCount == G - 1 && expQ.size() == FIFO_DEPTH);
  endfunction

  task automatic clearModel();
    expQ.delete();
    beatCount  = 0;
    pixelIndex = 0;
    accFmap    = '0;
    accPidx    = '0;
  endtask

  // Compare the DUT outputs against the model state
  task automatic checkModel();
    checkOutput("in_ready", in_ready, modelReady());
    checkOutput("out_valid", out_valid, expQ.size() != 0);
    if (expQ.size() != 0) begin
      checkOutput("out_fmap", out_fmap, expQ[0].fmap);
      checkOutput("out_pindex", out_pindex, expQ[0].pidx);
      checkOutput("out_last", out_last, expQ[0].last);
    end
  endtask

  // One cycle: check at the falling edge, drive, then advance the model
  task automatic applyStimulus(input logic v, input logic [N_PE-1:0] b, input logic [BPW-1:0] p, input logic r);
    bit acc;
    bit doPop;
    pixel_t px;
    checkModel();
    in_valid  = v;
    in_bits   = b;
    in_pindex = p;
    out_ready = r;
    acc   = v && modelReady();
    doPop = r && (expQ.size() != 0);
    @(posedge clk);
    if (doPop) void'(expQ.pop_front());
    if (acc) begin
      accFmap = (accFmap << N_PE) | D_OUT'(b);
      accPidx = (accPidx << BPW) | PW'(p);
      beatCount++;
      if (beatCount == G) begin
        px.fmap = accFmap;
        px.pidx = accPidx;
        px.last = (pixelIndex == N_PIXELS - 1);
        expQ.push_back(px);
        pixelIndex = (pixelIndex + 1) % N_PIXELS;
        beatCount  = 0;
        accFmap    = '0;
        accPidx    = '0;
      end
    end
    @(negedge clk);
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearModel();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_bits    = '0;
    in_pindex  = '0;
    out_ready  = 1'b0;
    clearModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_out_fmap", out_fmap, 0);
    checkOutput("rst_out_pindex", out_pindex, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    // Basic pack
    applyStimulus(1'b1, 4'b1010, 8'hE4, 1'b1);
    checkOutput("basic_valid_early", out_valid, 0);
    applyStimulus(1'b1, 4'b0111, 8'h1B, 1'b1);
    checkOutput("basic_valid", out_valid, 1);
    checkOutput("basic_fmap", out_fmap, 8'hA7);
    checkOutput("basic_pindex", out_pindex, 16'hE41B);
    checkOutput("basic_last", out_last, 0);
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);

    // Frame end: only pixel 2 carries last, pixel 3 wraps to index 0
    resetDut();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, N_PE'($urandom), BPW'($urandom), 1'b1);
      applyStimulus(1'b1, N_PE'($urandom), BPW'($urandom), 1'b1);
      checkOutput("frame_valid", out_valid, 1);
      checkOutput("frame_last", out_last, (k == N_PIXELS - 1));
    end
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);

    // Backpressure: two pixels fill the FIFO, the completing 6th beat stalls
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, N_PE'(i + 1), BPW'(8'h10 * i + 3), 1'b0);
    end
    checkOutput("bp_ready_full", in_ready, 0);
    applyStimulus(1'b1, 4'h6, 8'h66, 1'b1);
    checkOutput("bp_ready_after_pop", in_ready, 1);
    applyStimulus(1'b1, 4'h6, 8'h66, 1'b0);
    repeat (4) applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
    checkOutput("bp_drained", out_valid, 0);

    // Stable hold of the head while the consumer stalls
    resetDut();
    applyStimulus(1'b1, 4'h5, 8'h3C, 1'b0);
    applyStimulus(1'b1, 4'hC, 8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_fmap", out_fmap, 8'h5C);
      checkOutput("hold_pindex", out_pindex, 16'h3CA5);
      checkOutput("hold_last", out_last, 0);
      applyStimulus(1'b0, 4'hF, 8'hFF, 1'b0);
    end

    // Reset mid-assembly discards the partial pixel
    resetDut();
    applyStimulus(1'b1, 4'hF, 8'hFF, 1'b1);
    resetDut();
    checkOutput("midrst_valid", out_valid, 0);
    applyStimulus(1'b1, 4'h0, 8'h00, 1'b1);
    checkOutput("midrst_valid_pending", out_valid, 0);
    applyStimulus(1'b1, 4'h0, 8'h00, 1'b0);
    checkOutput("midrst_new_valid", out_valid, 1);
    checkOutput("midrst_fmap", out_fmap, 8'h00);
    checkOutput("midrst_last", out_last, 0);
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);

    // Gapped input: idle cycles do not advance the group
    resetDut();
    applyStimulus(1'b1, 4'h9, 8'h12, 1'b0);
    applyStimulus(1'b0, 4'hF, 8'hFF, 1'b0);
    applyStimulus(1'b0, 4'hF, 8'hFF, 1'b0);
    checkOutput("gap_no_pixel", out_valid, 0);
    applyStimulus(1'b1, 4'h6, 8'h34, 1'b0);
    checkOutput("gap_valid", out_valid, 1);
    checkOutput("gap_fmap", out_fmap, 8'h96);
    checkOutput("gap_pindex", out_pindex, 16'h1234);
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
    checkOutput("gap_single_pixel", out_valid, 0);

    // Randomized traffic against the model
    resetDut();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, N_PE'($urandom), BPW'($urandom), ($urandom % 2) == 0);
    end
    repeat (8) applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
    checkModel();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ec_out_packer.md
Name: ec_out_packer

Overview:
- Sits directly downstream of a bank of N_PE encoder PEs. Each PE emits one binarized output channel bit plus a 2x2 max-pool index per cycle.
- Collects G = D_OUT/N_PE consecutive PE-bank results into one full output pixel: a D_OUT-bit feature word plus D_OUT pool indices.
- Buffers assembled pixels in a small FIFO and streams them to the fmap writer / decoder unpool-index store with valid/ready and frame-end marking.

Parameters:
- N_PE, 16, number of parallel PE instances (channels per input beat).
- D_OUT, 64, output channels per pixel; must be a multiple of N_PE.
- PINDEX_WIDTH, 2, pool-index width per channel ($clog2(POOL_H*POOL_W)).
- FIFO_DEPTH, 4, assembled-pixel FIFO entries; power of 2, >= 2.
- N_PIXELS, 1024, pooled output pixels per frame.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  PE-bank result beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_bits  in  N_PE  binarized PE outputs; MSB = lowest channel of the group.
- in_pindex  in  N_PE*PINDEX_WIDTH  pool indices; the MSB field pairs with the in_bits MSB.
- out_valid  out  1  assembled pixel available.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_fmap  out  D_OUT  packed pixel; channel c is at bit D_OUT-1-c.
- out_pindex  out  D_OUT*PINDEX_WIDTH  channel c occupies the field starting at the MSB end, index c.
- out_last  out  1  high with the final pixel (index N_PIXELS-1) of a frame.

Behaviour:
- Reset values: out_valid=0, out_last=0, out_fmap=0, out_pindex=0, in_ready=1. Group counter, pixel counter and FIFO count are all 0.
- Reset mid-assembly discards the partial pixel and all FIFO contents; there is no partial output.
- Channel mapping: beat g (0..G-1) of a pixel carries channels g*N_PE .. g*N_PE+N_PE-1. Beat g lands at out_fmap[D_OUT-1-g*N_PE -: N_PE]; pindex is placed the same way, MSB-first.
- Assembly state: grp_cnt in 0..G-1. On each accepted beat, write the beat slice into the assembly register and increment grp_cnt.
- When the beat with grp_cnt==G-1 is accepted:
  - the full word (assembly register plus this beat) is pushed into the FIFO in the same cycle;
  - grp_cnt wraps to 0;
  - pix_cnt increments, wrapping N_PIXELS-1 -> 0;
  - the pushed entry carries last = (pix_cnt==N_PIXELS-1).
- in_ready = !(grp_cnt==G-1 && fifo_full). It is registered-state only, with no combinational path from out_ready. Beats with grp_cnt<G-1 are always accepted.
- G==1 case: every beat is a push, so in_ready = !fifo_full.
- FIFO behaviour:
  - out_valid = !fifo_empty; out_fmap/out_pindex/out_last are the head entry.
  - The head is held stable while out_valid && !out_ready.
  - Simultaneous push and pop when neither full nor empty: count unchanged, order preserved.
  - Push into an empty FIFO: out_valid rises the next cycle. Minimum latency from the final-beat accept to out_valid is 1 cycle.
  - When full, a pop does not enable a same-cycle push; in_ready rises the cycle after the pop.
- in_valid low: no state change in the assembly path. in_bits/in_pindex are don't-care.
- Throughput: one pixel every G cycles sustained, given out_ready=1.
- No overflow or underflow is possible by construction. Verification asserts count <= FIFO_DEPTH and that no pop occurs when empty.

Decomposition:
- Package ec_pkg:
  - localparam G = D_OUT/N_PE;
  - GRP_W = $clog2(G) (min 1);
  - PIX_W = $clog2(N_PIXELS);
  - ENTRY_W = D_OUT + D_OUT*PINDEX_WIDTH + 1;
  - the entry-packing order {last, fmap, pindex}.
- Sub-module ec_word_fifo (parameters WIDTH, DEPTH):
  - synchronous FIFO with rst, push, pop, full, empty and head data;
  - pointer-plus-count implementation.
- The packer keeps the counters and assembly register.

Test Plan (N_PE=4, D_OUT=8, PINDEX_WIDTH=2, FIFO_DEPTH=2, N_PIXELS=3; G=2):
- Basic pack: beats in_bits=4'b1010, pindex=8'hE4, then 4'b0111, 8'h1B, with out_ready=1 -> out_fmap=8'hA7, out_pindex=16'hE41B, out_last=0. out_valid rises 1 cycle after the 2nd beat.
- Frame end: stream 3 pixels (6 beats) -> out_last=1 only on the 3rd pixel. The 4th pixel's out_last=0 because pix_cnt wrapped.
- Backpressure: out_ready=0 while 3 pixels are offered -> FIFO holds 2. in_ready=1 on the 5th beat, in_ready=0 on the 6th. Raise out_ready for 1 cycle -> in_ready=1 next cycle, the 6th beat is accepted, and order is preserved as pixels 0,1,2.
- Stable hold: out_ready=0 for 5 cycles with out_valid=1 -> out_fmap/out_pindex/out_last are unchanged every cycle.
- Reset mid-assembly: accept beat 0 (4'hF), assert rst for 1 cycle, then send 4'h0,4'h0 -> out_fmap=8'h00 with pixel index 0. out_valid=0 during and after reset until the new push.
- Gapped input: in_valid toggles 1,0,0,1 -> exactly one pixel is formed from the two valid beats. grp_cnt ignores idle cycles.
